// File: rtl/alu_exec_unit.sv
// Purpose : EX-stage MIPS ALU; single-cycle ops plus iterative shift-add MULT/MULTU into Hi/Lo.
// Latency : single-cycle ops complete 1 edge after accept; MULT/MULTU complete WIDTH+2 edges after accept.
// Backpressure: In_Ready=1 only in IDLE; during a multiply In_Ready=0, Busy=1 and In_Valid is ignored.
//
// Ports: Clock/Reset_n (async active-low); In_Valid/In_Ready handshake; OpCode_ALU, Func_Code, Shamt,
//        Operand_A, Operand_B operation inputs; Out_Valid pulse with registered Result, Zero, Overflow,
//        Illegal; Busy while multiplying; Hi/Lo hold the last multiply product.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               In_Valid,
    output logic               In_Ready,
    input  logic [1:0]         OpCode_ALU,
    input  logic [5:0]         Func_Code,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic [WIDTH-1:0]   Operand_A,
    input  logic [WIDTH-1:0]   Operand_B,
    output logic               Out_Valid,
    output logic [WIDTH-1:0]   Result,
    output logic               Zero,
    output logic               Overflow,
    output logic               Illegal,
    output logic               Busy,
    output logic [WIDTH-1:0]   Hi,
    output logic [WIDTH-1:0]   Lo
);

    localparam logic [5:0] FN_SLL   = 6'd0;
    localparam logic [5:0] FN_SRL   = 6'd2;
    localparam logic [5:0] FN_SRA   = 6'd3;
    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;
    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_ADDU  = 6'd33;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_SUBU  = 6'd35;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_XOR   = 6'd38;
    localparam logic [5:0] FN_NOR   = 6'd39;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_SLTU  = 6'd43;

    localparam logic [SHAMT_W:0] CNT_LAST = WIDTH[SHAMT_W:0];
    localparam logic [SHAMT_W:0] CNT_ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_t;

    state_t state, state_nxt;

    logic                 accept;
    logic [WIDTH-1:0]     sum, diff;
    logic                 add_ovf, sub_ovf, slt_s, slt_u;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_ovf, alu_ill, mul_op, mul_sgn;
    logic [WIDTH-1:0]     mag_a, mag_b;

    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   prod, prod_fix;
    logic [WIDTH:0]       part;
    logic [SHAMT_W:0]     cnt;
    logic                 neg;

    assign accept = In_Valid & In_Ready;

    assign sum     = Operand_A + Operand_B;
    assign diff    = Operand_A - Operand_B;
    // Signed overflow: result sign disagrees with what the operand signs demand.
    assign add_ovf = (Operand_A[WIDTH-1] == Operand_B[WIDTH-1]) && (sum[WIDTH-1] != Operand_A[WIDTH-1]);
    assign sub_ovf = (Operand_A[WIDTH-1] != Operand_B[WIDTH-1]) && (diff[WIDTH-1] != Operand_A[WIDTH-1]);
    assign slt_s   = $signed(Operand_A) < $signed(Operand_B);
    assign slt_u   = Operand_A < Operand_B;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        mul_op  = 1'b0;
        mul_sgn = 1'b0;
        case (OpCode_ALU)
            2'd0: begin alu_res = sum;  alu_ovf = add_ovf; end
            2'd1: begin alu_res = diff; alu_ovf = sub_ovf; end
            2'd3: alu_res = {{(WIDTH-1){1'b0}}, slt_s};
            default: begin
                case (Func_Code)
                    FN_SLL:   alu_res = Operand_B << Shamt;
                    FN_SRL:   alu_res = Operand_B >> Shamt;
                    FN_SRA:   alu_res = $signed(Operand_B) >>> Shamt;
                    FN_ADD:   begin alu_res = sum;  alu_ovf = add_ovf; end
                    FN_ADDU:  alu_res = sum;
                    FN_SUB:   begin alu_res = diff; alu_ovf = sub_ovf; end
                    FN_SUBU:  alu_res = diff;
                    FN_AND:   alu_res = Operand_A & Operand_B;
                    FN_OR:    alu_res = Operand_A | Operand_B;
                    FN_XOR:   alu_res = Operand_A ^ Operand_B;
                    FN_NOR:   alu_res = ~(Operand_A | Operand_B);
                    FN_SLT:   alu_res = {{(WIDTH-1){1'b0}}, slt_s};
                    FN_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, slt_u};
                    FN_MFHI:  alu_res = Hi;
                    FN_MFLO:  alu_res = Lo;
                    FN_MULT:  begin mul_op = 1'b1; mul_sgn = 1'b1; end
                    FN_MULTU: mul_op = 1'b1;
                    default:  alu_ill = 1'b1;
                endcase
            end
        endcase
    end

    // Magnitudes for signed multiply; the most-negative value maps to 2^(WIDTH-1) as unsigned.
    assign mag_a = (mul_sgn && Operand_A[WIDTH-1]) ? -Operand_A : Operand_A;
    assign mag_b = (mul_sgn && Operand_B[WIDTH-1]) ? -Operand_B : Operand_B;

    // One shift-add step: low half holds the remaining multiplier bits, high half the partial sum.
    assign part     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    assign prod_fix = neg ? -prod : prod;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        In_Ready  = 1'b0;
        Busy      = 1'b0;
        case (state)
            S_IDLE: begin
                In_Ready = 1'b1;
                if (In_Valid && mul_op) state_nxt = S_MUL;
            end
            S_MUL: begin
                Busy = 1'b1;
                if (cnt == CNT_LAST) state_nxt = S_FIX;
            end
            S_FIX: begin
                Busy      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Out_Valid <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b0;
            Overflow  <= 1'b0;
            Illegal   <= 1'b0;
            Hi        <= '0;
            Lo        <= '0;
            mcand     <= '0;
            prod      <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
        end else begin
            Out_Valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (mul_op) begin
                            mcand <= mag_a;
                            prod  <= {{WIDTH{1'b0}}, mag_b};
                            cnt   <= '0;
                            neg   <= mul_sgn & (Operand_A[WIDTH-1] ^ Operand_B[WIDTH-1]);
                        end else begin
                            Out_Valid <= 1'b1;
                            Result    <= alu_res;
                            Zero      <= (alu_res == '0);
                            Overflow  <= alu_ovf;
                            Illegal   <= alu_ill;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt != CNT_LAST) begin
                        prod <= {part, prod[WIDTH-1:1]};
                        cnt  <= cnt + CNT_ONE;
                    end
                end
                S_FIX: begin
                    Hi        <= prod_fix[2*WIDTH-1:WIDTH];
                    Lo        <= prod_fix[WIDTH-1:0];
                    Result    <= prod_fix[WIDTH-1:0];
                    Zero      <= (prod_fix[WIDTH-1:0] == '0);
                    Overflow  <= 1'b0;
                    Illegal   <= 1'b0;
                    Out_Valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        Clock = 1'b0;
    logic        Reset_n;

    // 32-bit instance
    logic        in_valid, in_ready, out_valid, zero, overflow, illegal, busy;
    logic [1:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  shamt;
    logic [31:0] op_a, op_b, result, hi, lo;

    // 8-bit instance
    logic        in_valid8, in_ready8, out_valid8, zero8, overflow8, illegal8, busy8;
    logic [5:0]  func8;
    logic [7:0]  op_a8, op_b8, result8, hi8, lo8;

    int checks = 0;
    int errors = 0;

    logic [31:0] hi_m, lo_m, last_res;

    always #5 Clock = ~Clock;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .In_Valid(in_valid), .In_Ready(in_ready),
        .OpCode_ALU(opcode), .Func_Code(func), .Shamt(shamt), .Operand_A(op_a), .Operand_B(op_b),
        .Out_Valid(out_valid), .Result(result), .Zero(zero), .Overflow(overflow), .Illegal(illegal),
        .Busy(busy), .Hi(hi), .Lo(lo)
    );

    alu_exec_unit #(.WIDTH(8), .SHAMT_W(3)) dut8 (
        .Clock(Clock), .Reset_n(Reset_n), .In_Valid(in_valid8), .In_Ready(in_ready8),
        .OpCode_ALU(2'd2), .Func_Code(func8), .Shamt(3'd0), .Operand_A(op_a8), .Operand_B(op_b8),
        .Out_Valid(out_valid8), .Result(result8), .Zero(zero8), .Overflow(overflow8), .Illegal(illegal8),
        .Busy(busy8), .Hi(hi8), .Lo(lo8)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model for single-cycle operations, from the instruction semantics.
    task automatic model(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic ovf, output logic ill);
        longint sa, sb, s;
        logic [31:0] ones;
        sa = $signed(a);
        sb = $signed(b);
        ones = 32'hFFFF_FFFF;
        res = 32'h0;
        ovf = 1'b0;
        ill = 1'b0;
        if (op == 2'd0 || (op == 2'd2 && (fn == 6'd32 || fn == 6'd33))) begin
            s = sa + sb;
            res = s[31:0];
            ovf = (fn == 6'd32 || op == 2'd0) && (s != longint'($signed(s[31:0])));
        end else if (op == 2'd1 || (op == 2'd2 && (fn == 6'd34 || fn == 6'd35))) begin
            s = sa - sb;
            res = s[31:0];
            ovf = (fn == 6'd34 || op == 2'd1) && (s != longint'($signed(s[31:0])));
        end else if (op == 2'd3) begin
            res = (sa < sb) ? 32'd1 : 32'd0;
        end else begin
            case (fn)
                6'd0:  res = b << sh;
                6'd2:  res = b >> sh;
                6'd3:  res = (b >> sh) | (b[31] ? ~(ones >> sh) : 32'h0);
                6'd36: res = a & b;
                6'd37: res = a | b;
                6'd38: res = a ^ b;
                6'd39: res = ~(a | b);
                6'd42: res = (sa < sb) ? 32'd1 : 32'd0;
                6'd43: res = (a < b) ? 32'd1 : 32'd0;
                6'd16: res = hi_m;
                6'd18: res = lo_m;
                default: ill = 1'b1;
            endcase
        end
    endtask

    task automatic run_single(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        logic ovf, ill;
        model(op, fn, sh, a, b, res, ovf, ill);
        in_valid = 1'b1; opcode = op; func = fn; shamt = sh; op_a = a; op_b = b;
        @(posedge Clock);
        @(negedge Clock);
        in_valid = 1'b0;
        check_eq("out_valid", out_valid, 1'b1);
        check_eq("result", result, res);
        check_eq("zero", zero, res == 32'h0);
        check_eq("overflow", overflow, ovf);
        check_eq("illegal", illegal, ill);
        last_res = res;
    endtask

    task automatic idle_cycle();
        @(posedge Clock);
        @(negedge Clock);
        check_eq("idle_no_valid", out_valid, 1'b0);
        check_eq("idle_hold", result, last_res);
    endtask

    task automatic run_mul(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        int k;
        logic done, rdy_seen;
        logic [63:0] p;
        longint sa, sb;
        in_valid = 1'b1; opcode = 2'd2; func = sgn ? 6'd24 : 6'd25; shamt = 5'd0; op_a = a; op_b = b;
        @(posedge Clock);
        @(negedge Clock);
        // Present a live ADD during the multiply; it must be ignored.
        func = 6'd32; op_a = $urandom; op_b = $urandom;
        k = 0; done = 1'b0; rdy_seen = 1'b0;
        while (k < 60 && !done) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) rdy_seen = 1'b1;
            @(posedge Clock);
            k++;
            @(negedge Clock);
            if (out_valid === 1'b1) done = 1'b1;
        end
        in_valid = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        p = sgn ? 64'(sa * sb) : ({32'h0, a} * {32'h0, b});
        hi_m = p[63:32];
        lo_m = p[31:0];
        last_res = lo_m;
        check_eq("mul_done", done, 1'b1);
        check_eq("mul_latency", k, 34);
        check_eq("mul_stall", rdy_seen, 1'b0);
        check_eq("mul_hi", hi, hi_m);
        check_eq("mul_lo", lo, lo_m);
        check_eq("mul_result", result, lo_m);
        check_eq("mul_zero", zero, lo_m == 32'h0);
        check_eq("mul_ovf", overflow, 1'b0);
        check_eq("mul_ill", illegal, 1'b0);
        check_eq("mul_ready_after", in_ready, 1'b1);
    endtask

    task automatic run_mul8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
        int k, sa, sb, p;
        logic done;
        in_valid8 = 1'b1; func8 = sgn ? 6'd24 : 6'd25; op_a8 = a; op_b8 = b;
        @(posedge Clock);
        @(negedge Clock);
        in_valid8 = 1'b0;
        k = 0; done = 1'b0;
        while (k < 30 && !done) begin
            @(posedge Clock);
            k++;
            @(negedge Clock);
            if (out_valid8 === 1'b1) done = 1'b1;
        end
        sa = sgn ? int'($signed(a)) : int'(a);
        sb = sgn ? int'($signed(b)) : int'(b);
        p = sa * sb;
        check_eq("mul8_done", done, 1'b1);
        check_eq("mul8_latency", k, 10);
        check_eq("mul8_hi", hi8, p[15:8]);
        check_eq("mul8_lo", lo8, p[7:0]);
        check_eq("mul8_zero", zero8, p[7:0] == 8'h0);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [5];
        corners = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [5:0] fn_tab [15];
        logic [1:0] op;
        logic [5:0] fn;
        int no_pulse;
        fn_tab = '{6'd0, 6'd2, 6'd3, 6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38,
                   6'd39, 6'd42, 6'd43, 6'd16, 6'd18};
        Reset_n = 1'b0;
        in_valid = 1'b0; opcode = 2'd0; func = 6'd0; shamt = 5'd0; op_a = 32'h0; op_b = 32'h0;
        in_valid8 = 1'b0; func8 = 6'd0; op_a8 = 8'h0; op_b8 = 8'h0;
        hi_m = 32'h0; lo_m = 32'h0; last_res = 32'h0;
        repeat (3) @(negedge Clock);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_result", result, 32'h0);
        check_eq("rst_zero", zero, 1'b0);
        check_eq("rst_flags", {overflow, illegal, busy}, 3'b000);
        check_eq("rst_ready", in_ready, 1'b1);
        check_eq("rst_hilo", {hi, lo}, 64'h0);
        Reset_n = 1'b1;
        @(negedge Clock);

        // Directed cases
        run_single(2'd2, 6'd32, 5'd0, 32'd5, 32'd7);
        check_eq("add_5_7", result, 32'd12);
        run_single(2'd1, 6'd0, 5'd0, 32'h1234, 32'h1234);
        check_eq("beq_zero", zero, 1'b1);
        run_single(2'd2, 6'd32, 5'd0, 32'h7FFF_FFFF, 32'h1);
        check_eq("add_ovf_res", result, 32'h8000_0000);
        run_single(2'd2, 6'd33, 5'd0, 32'd1, 32'd2);
        check_eq("ovf_cleared", overflow, 1'b0);
        run_single(2'd2, 6'd3, 5'd4, 32'h0, 32'h8000_0000);
        check_eq("sra", result, 32'hF800_0000);
        run_single(2'd2, 6'd2, 5'd4, 32'h0, 32'h8000_0000);
        check_eq("srl", result, 32'h0800_0000);
        run_single(2'd2, 6'd43, 5'd0, 32'h1, 32'hFFFF_FFFF);
        check_eq("sltu", result, 32'h1);
        idle_cycle();

        run_mul(1'b1, -32'sd3, 32'd7);
        check_eq("mult_hi_lit", hi, 32'hFFFF_FFFF);
        check_eq("mult_lo_lit", lo, 32'hFFFF_FFEB);
        run_single(2'd2, 6'd16, 5'd0, 32'h0, 32'h0);
        check_eq("mfhi_lit", result, 32'hFFFF_FFFF);
        run_mul(1'b0, 32'hFFFF_FFFF, 32'd2);
        check_eq("multu_hi_lit", hi, 32'h1);
        check_eq("multu_lo_lit", lo, 32'hFFFF_FFFE);
        run_mul(1'b1, 32'h8000_0000, 32'h8000_0000);
        run_single(2'd2, 6'd63, 5'd0, 32'h55, 32'h66);
        check_eq("illegal_hi_keep", hi, hi_m);
        check_eq("illegal_lo_keep", lo, lo_m);

        // Randomized mix, issued back to back
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 14)];
            if ($urandom_range(0, 19) == 0) begin
                run_mul(1'($urandom), pick(), pick());
            end else if (op == 2'd2 && (fn == 6'd24 || fn == 6'd25)) begin
                run_mul(fn == 6'd24, pick(), pick());
            end else begin
                run_single(op, fn, 5'($urandom), pick(), pick());
            end
            if ($urandom_range(0, 9) == 0) idle_cycle();
        end

        // Reset in the middle of a multiply
        in_valid = 1'b1; opcode = 2'd2; func = 6'd24; op_a = 32'd1234; op_b = 32'd5678;
        @(posedge Clock);
        @(negedge Clock);
        in_valid = 1'b0;
        repeat (10) @(posedge Clock);
        #1 Reset_n = 1'b0;
        #1;
        check_eq("mrst_busy", busy, 1'b0);
        check_eq("mrst_hilo", {hi, lo}, 64'h0);
        check_eq("mrst_out_valid", out_valid, 1'b0);
        hi_m = 32'h0; lo_m = 32'h0; last_res = 32'h0;
        @(negedge Clock);
        Reset_n = 1'b1;
        no_pulse = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clock);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) no_pulse++;
        end
        check_eq("mrst_quiet", no_pulse, 0);
        run_single(2'd2, 6'd18, 5'd0, 32'h0, 32'h0);

        // Narrow instance
        run_mul8(1'b1, 8'h80, 8'h80);
        check_eq("mul8_hi_lit", hi8, 8'h40);
        check_eq("mul8_lo_lit", lo8, 8'h00);
        for (int i = 0; i < 8; i++) run_mul8(1'($urandom), 8'($urandom), 8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
